// File: rtl/instr_fetch.sv
// Instruction fetch unit: sequences instruction-memory reads, holds the fetched
// instruction until the decoder accepts it, and computes the next PC from either
// pc+1 or a 4-entry jump-target table, gated by opcode-selected flag conditions.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   start, end_pc           begin execution at PC 0; first address past program
//   imem_en, imem_addr      instruction-memory read request
//   imem_data               read data, valid one cycle after imem_en
//   instr, instr_valid      fetched instruction handed to the decoder
//   instr_ready             decoder accept
//   pc                      address of the instruction in instr
//   branch, jump_sel        branch request and jump-table index for instr
//   flag_we, *_in, flags    ALU flag capture, registered {zero,sign,carry,ovf}
//   lut_we/idx/data         jump-target table write port
//   done                    program finished
module instr_fetch #(
  parameter int unsigned IW = 9,
  parameter int unsigned PW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [PW-1:0] end_pc,
  output logic          imem_en,
  output logic [PW-1:0] imem_addr,
  input  logic [IW-1:0] imem_data,
  output logic [IW-1:0] instr,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [PW-1:0] pc,
  input  logic          branch,
  input  logic [1:0]    jump_sel,
  input  logic          flag_we,
  input  logic          zero_in,
  input  logic          sign_in,
  input  logic          carry_in,
  input  logic          ovf_in,
  output logic [3:0]    flags,
  input  logic          lut_we,
  input  logic [1:0]    lut_idx,
  input  logic [PW-1:0] lut_data,
  output logic          done
);

  localparam int unsigned OPW  = 4;
  localparam int unsigned NLUT = 4;

  localparam logic [OPW-1:0] OP_BEQ = 4'b1011;
  localparam logic [OPW-1:0] OP_BGE = 4'b1100;
  localparam logic [OPW-1:0] OP_BLE = 4'b1101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_VALID,
    S_DONE
  } state_t;

  state_t         state;
  logic [PW-1:0]  lut [NLUT];
  logic [OPW-1:0] opcode;
  logic           cond;
  logic           taken;
  logic [PW-1:0]  next_pc;

  assign opcode = instr[IW-1 -: OPW];

  // Branch condition from opcode, evaluated on the registered flags only.
  always_comb begin
    cond = 1'b0;
    case (opcode)
      OP_BEQ:  cond = flags[3];
      OP_BGE:  cond = (flags[2] == flags[0]);
      OP_BLE:  cond = flags[3] | (flags[2] != flags[0]);
      default: cond = 1'b0;
    endcase
  end

  assign taken = branch & cond;

  // Table read uses the pre-edge contents, so a same-cycle write is not seen.
  assign next_pc = taken ? lut[jump_sel] : PW'(pc + PW'(1));

  // Control FSM with registered outputs; flags and table update in every state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      pc          <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      imem_en     <= 1'b0;
      imem_addr   <= '0;
      done        <= 1'b0;
      flags       <= '0;
      for (int i = 0; i < int'(NLUT); i++) lut[i] <= '0;
    end else begin
      if (flag_we) flags <= {zero_in, sign_in, carry_in, ovf_in};
      if (lut_we) lut[lut_idx] <= lut_data;

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_FETCH;
            pc        <= '0;
            imem_en   <= 1'b1;
            imem_addr <= '0;
            done      <= 1'b0;
          end
        end
        S_FETCH: begin
          state   <= S_WAIT;
          imem_en <= 1'b0;
        end
        S_WAIT: begin
          state       <= S_VALID;
          instr       <= imem_data;
          instr_valid <= 1'b1;
        end
        S_VALID: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            pc          <= next_pc;
            if (next_pc == end_pc) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state     <= S_FETCH;
              imem_en   <= 1'b1;
              imem_addr <= next_pc;
            end
          end
        end
        default: begin
          state       <= S_IDLE;
          imem_en     <= 1'b0;
          instr_valid <= 1'b0;
          done        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch (IW=9, PW=4): directed scenarios with
// literal expectations plus randomized traffic against a transaction-level model.
module tb_instr_fetch;

  localparam int unsigned IW    = 9;
  localparam int unsigned PW    = 4;
  localparam int unsigned DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [PW-1:0] end_pc;
  logic          imem_en;
  logic [PW-1:0] imem_addr;
  logic [IW-1:0] imem_data;
  logic [IW-1:0] instr;
  logic          instr_valid;
  logic          instr_ready;
  logic [PW-1:0] pc;
  logic          branch;
  logic [1:0]    jump_sel;
  logic          flag_we, zero_in, sign_in, carry_in, ovf_in;
  logic [3:0]    flags;
  logic          lut_we;
  logic [1:0]    lut_idx;
  logic [PW-1:0] lut_data;
  logic          done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [IW-1:0] rom [DEPTH];

  instr_fetch #(.IW(IW), .PW(PW)) dut (
    .clk(clk), .reset(reset), .start(start), .end_pc(end_pc),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_data(imem_data),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc(pc), .branch(branch), .jump_sel(jump_sel),
    .flag_we(flag_we), .zero_in(zero_in), .sign_in(sign_in),
    .carry_in(carry_in), .ovf_in(ovf_in), .flags(flags),
    .lut_we(lut_we), .lut_idx(lut_idx), .lut_data(lut_data), .done(done)
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction memory: data one cycle after the enable.
  always @(posedge clk) if (imem_en) imem_data <= rom[imem_addr];

  // ---------------- reference model ----------------
  // Execution is a sequence of instructions, each taking a fetch cycle, a wait
  // cycle and then one or more presentation cycles until accepted.
  bit            m_run, m_done;
  int            m_cyc;
  logic [PW-1:0] m_pc;
  logic [IW-1:0] m_instr;
  logic [3:0]    m_flags;
  logic [PW-1:0] m_tab [4];

  function automatic bit m_taken(input logic [3:0] op, input logic [3:0] f, input logic br);
    bit z, s, v;
    z = f[3]; s = f[2]; v = f[0];
    case (op)
      4'b1011: return br && z;
      4'b1100: return br && (s == v);
      4'b1101: return br && (z || (s != v));
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_run = 1'b0; m_done = 1'b0; m_cyc = 0;
      m_pc = '0; m_instr = '0; m_flags = '0;
      for (int i = 0; i < 4; i++) m_tab[i] = '0;
    end else begin
      logic [PW-1:0] nxt;
      if (m_run) begin
        if (m_cyc == 0) m_cyc = 1;
        else if (m_cyc == 1) begin
          m_instr = rom[m_pc];
          m_cyc = 2;
        end else if (instr_ready) begin
          if (m_taken(m_instr[IW-1:IW-4], m_flags, branch)) nxt = m_tab[jump_sel];
          else nxt = PW'((int'(m_pc) + 1) % int'(DEPTH));
          m_pc = nxt;
          if (nxt == end_pc) begin
            m_run = 1'b0;
            m_done = 1'b1;
          end else m_cyc = 0;
        end
      end else if (start) begin
        m_run = 1'b1; m_done = 1'b0; m_pc = '0; m_cyc = 0;
      end
      if (flag_we) m_flags = {zero_in, sign_in, carry_in, ovf_in};
      if (lut_we) m_tab[lut_idx] = lut_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle compare against the model.
  always begin
    @(posedge clk);
    #2;
    if (reset === 1'b0) begin
      chk("m_imem_en", 32'(imem_en), 32'(m_run && m_cyc == 0));
      chk("m_instr_valid", 32'(instr_valid), 32'(m_run && m_cyc == 2));
      chk("m_done", 32'(done), 32'(m_done));
      chk("m_pc", 32'(pc), 32'(m_pc));
      chk("m_instr", 32'(instr), 32'(m_instr));
      chk("m_flags", 32'(flags), 32'(m_flags));
      if (m_run && m_cyc == 0) chk("m_imem_addr", 32'(imem_addr), 32'(m_pc));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #4;
    end
  endtask

  task automatic idle_inputs();
    start = 1'b0; instr_ready = 1'b0; branch = 1'b0; jump_sel = '0;
    flag_we = 1'b0; zero_in = 1'b0; sign_in = 1'b0; carry_in = 1'b0; ovf_in = 1'b0;
    lut_we = 1'b0; lut_idx = '0; lut_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick();
  endtask

  task automatic set_flags(input logic [3:0] f);
    {zero_in, sign_in, carry_in, ovf_in} = f;
    flag_we = 1'b1;
    tick();
    flag_we = 1'b0;
  endtask

  task automatic set_lut(input logic [1:0] idx, input logic [PW-1:0] val);
    lut_we = 1'b1; lut_idx = idx; lut_data = val;
    tick();
    lut_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int i;
    i = 0;
    while (instr_valid !== 1'b1 && i < 20) begin
      tick();
      i++;
    end
    if (instr_valid !== 1'b1) chk({tag, "_valid_timeout"}, 32'(instr_valid), 32'd1);
  endtask

  typedef struct packed {
    logic [1:0]    idx;
    logic [PW-1:0] tgt;
    logic [3:0]    fl;
    logic [3:0]    op;
    logic          br;
    logic          fw;
    logic [PW-1:0] exp;
  } bcase_t;

  bcase_t bc [10];

  // One branch decision from PC 0: check the address of the following fetch.
  task automatic branch_case(input int n, input bcase_t c);
    do_reset();
    set_lut(c.idx, c.tgt);
    set_flags(c.fl);
    rom[0] = {c.op, 5'h15};
    end_pc = 4'hE;
    pulse_start();
    wait_valid($sformatf("br%0d", n));
    branch = c.br; jump_sel = c.idx; instr_ready = 1'b1;
    if (c.fw) begin
      {zero_in, sign_in, carry_in, ovf_in} = 4'b1000;
      flag_we = 1'b1;
    end
    tick();
    instr_ready = 1'b0; branch = 1'b0; flag_we = 1'b0;
    chk($sformatf("br%0d_en", n), 32'(imem_en), 32'd1);
    chk($sformatf("br%0d_addr", n), 32'(imem_addr), 32'(c.exp));
    if (c.fw) chk($sformatf("br%0d_flags", n), 32'(flags), 32'h8);
  endtask

  initial begin
    logic [IW-1:0] i0;
    logic [PW-1:0] p0;
    reset = 1'b1;
    end_pc = '0;
    idle_inputs();
    for (int r = 0; r < int'(DEPTH); r++) rom[r] = '0;
    tick(2);
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_en", 32'(imem_en), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    // Straight-line program of three non-branch instructions
    do_reset();
    for (int r = 0; r < int'(DEPTH); r++) rom[r] = {4'(r % 8), 5'(r + 3)};
    end_pc = 4'd3;
    instr_ready = 1'b1;
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("seq%0d_en", k), 32'(imem_en), 32'd1);
      chk($sformatf("seq%0d_addr", k), 32'(imem_addr), 32'(k));
      tick();
      chk($sformatf("seq%0d_wait", k), 32'(instr_valid), 32'd0);
      tick();
      chk($sformatf("seq%0d_valid", k), 32'(instr_valid), 32'd1);
      chk($sformatf("seq%0d_instr", k), 32'(instr), 32'(rom[k]));
      chk($sformatf("seq%0d_pc", k), 32'(pc), 32'(k));
      tick();
    end
    chk("seq_done", 32'(done), 32'd1);
    chk("seq_done_en", 32'(imem_en), 32'd0);
    chk("seq_done_pc", 32'(pc), 32'd3);
    instr_ready = 1'b0;

    // Stall in presentation
    do_reset();
    end_pc = 4'd8;
    pulse_start();
    wait_valid("stall");
    i0 = instr;
    p0 = pc;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_instr", 32'(instr), 32'(i0));
      chk("stall_pc", 32'(pc), 32'(p0));
      chk("stall_en", 32'(imem_en), 32'd0);
      chk("stall_valid", 32'(instr_valid), 32'd1);
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("stall_go_en", 32'(imem_en), 32'd1);
    chk("stall_go_addr", 32'(imem_addr), 32'd1);

    // Branch decisions: {idx, target, flags zscv, opcode, branch, flag write, expected addr}
    bc[0] = '{2'd2, 4'd7,  4'b1000, 4'hB, 1'b1, 1'b0, 4'd7};
    bc[1] = '{2'd2, 4'd7,  4'b0000, 4'hB, 1'b1, 1'b0, 4'd1};
    bc[2] = '{2'd1, 4'd9,  4'b0100, 4'hC, 1'b1, 1'b0, 4'd1};
    bc[3] = '{2'd1, 4'd9,  4'b0100, 4'hD, 1'b1, 1'b0, 4'd9};
    bc[4] = '{2'd1, 4'd9,  4'b0000, 4'hB, 1'b1, 1'b1, 4'd1};
    bc[5] = '{2'd3, 4'd12, 4'b1000, 4'hB, 1'b0, 1'b0, 4'd1};
    bc[6] = '{2'd3, 4'd12, 4'b1000, 4'hE, 1'b1, 1'b0, 4'd1};
    bc[7] = '{2'd0, 4'd6,  4'b0101, 4'hC, 1'b1, 1'b0, 4'd6};
    bc[8] = '{2'd0, 4'd6,  4'b1000, 4'hD, 1'b1, 1'b0, 4'd6};
    bc[9] = '{2'd0, 4'd6,  4'b0011, 4'hD, 1'b1, 1'b0, 4'd6};
    for (int n = 0; n < 10; n++) branch_case(n, bc[n]);

    // PC wrap from 15 to 0 on a non-branch accept
    do_reset();
    set_lut(2'd3, 4'd15);
    set_flags(4'b1000);
    rom[0] = {4'hB, 5'h01};
    rom[15] = {4'h2, 5'h0A};
    end_pc = 4'd9;
    branch = 1'b1; jump_sel = 2'd3; instr_ready = 1'b1;
    pulse_start();
    tick(3);
    chk("wrap_addr15", 32'(imem_addr), 32'd15);
    tick(2);
    chk("wrap_pc15", 32'(pc), 32'd15);
    tick();
    chk("wrap_pc0", 32'(pc), 32'd0);
    chk("wrap_addr0", 32'(imem_addr), 32'd0);
    chk("wrap_en", 32'(imem_en), 32'd1);
    idle_inputs();

    // Table write racing a branch through the same entry
    do_reset();
    set_lut(2'd1, 4'd5);
    set_flags(4'b1000);
    rom[0] = {4'hB, 5'h02};
    rom[5] = {4'hB, 5'h03};
    end_pc = 4'd14;
    branch = 1'b1; jump_sel = 2'd1;
    pulse_start();
    wait_valid("lut");
    instr_ready = 1'b1;
    lut_we = 1'b1; lut_idx = 2'd1; lut_data = 4'd12;
    tick();
    lut_we = 1'b0;
    chk("lut_old_addr", 32'(imem_addr), 32'd5);
    tick(3);
    chk("lut_new_addr", 32'(imem_addr), 32'd12);
    idle_inputs();

    // Reset in the memory-wait cycle
    do_reset();
    set_flags(4'b1101);
    rom[0] = {4'h3, 5'h11};
    rom[1] = {4'h4, 5'h12};
    end_pc = 4'd10;
    instr_ready = 1'b1;
    pulse_start();
    tick(3);
    instr_ready = 1'b0;
    tick();
    chk("wrst_pre_instr", 32'(instr), 32'(rom[0]));
    chk("wrst_pre_en", 32'(imem_en), 32'd0);
    reset = 1'b1;
    #1;
    chk("wrst_pc", 32'(pc), 32'd0);
    chk("wrst_instr", 32'(instr), 32'd0);
    chk("wrst_flags", 32'(flags), 32'd0);
    chk("wrst_valid", 32'(instr_valid), 32'd0);
    chk("wrst_en", 32'(imem_en), 32'd0);
    chk("wrst_done", 32'(done), 32'd0);
    tick();
    reset = 1'b0;
    tick(3);
    chk("wrst_idle_en", 32'(imem_en), 32'd0);
    chk("wrst_idle_valid", 32'(instr_valid), 32'd0);
    pulse_start();
    chk("wrst_restart_en", 32'(imem_en), 32'd1);
    chk("wrst_restart_addr", 32'(imem_addr), 32'd0);

    // Randomized traffic, model-checked every cycle
    for (int seg = 0; seg < 5; seg++) begin
      do_reset();
      for (int r = 0; r < int'(DEPTH); r++) begin
        case ($urandom_range(0, 3))
          0: rom[r] = {4'hB, 5'($urandom)};
          1: rom[r] = {4'hC, 5'($urandom)};
          2: rom[r] = {4'hD, 5'($urandom)};
          default: rom[r] = IW'($urandom);
        endcase
      end
      end_pc = PW'($urandom);
      for (int c = 0; c < 600; c++) begin
        start = ($urandom_range(0, 7) == 0);
        instr_ready = ($urandom_range(0, 3) != 0);
        branch = 1'($urandom);
        jump_sel = 2'($urandom);
        flag_we = ($urandom_range(0, 3) == 0);
        {zero_in, sign_in, carry_in, ovf_in} = 4'($urandom);
        lut_we = ($urandom_range(0, 5) == 0);
        lut_idx = 2'($urandom);
        lut_data = PW'($urandom);
        reset = ($urandom_range(0, 299) == 0);
        tick();
      end
      reset = 1'b0;
    end

    idle_inputs();
    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
